// File: rtl/fuel_pkg.sv
// Shared constants for the tank-level sensing path: data widths, default sensor
// timing at 50 MHz, and the echo-capture state encoding.
package fuel_pkg;

  localparam int unsigned DIST_W = 21;
  localparam int unsigned HOLD_W = 22;

  localparam int unsigned TRIG_CYCLES_DEF    = 500;
  localparam int unsigned RISE_TIMEOUT_DEF   = 1_000_000;
  localparam int unsigned ECHO_MAX_DEF       = 1_900_000;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 2_500_000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_TRIG      = ST_TRIG,
    S_WAIT_RISE = ST_WAIT_RISE,
    S_MEASURE   = ST_MEASURE,
    S_HOLDOFF   = ST_HOLDOFF
  } echo_state_t;

endpackage

// File: rtl/ultrasonic_echo_capture_echo_sync.sv
// Two-flop synchroniser for the asynchronous ECHO pin plus edge pulses.
// Rise and fall see the same delay, so pulse width is preserved exactly.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= echo;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/ultrasonic_echo_capture.sv
// HC-SR04 driver: fires TRIG, times the ECHO high width in clk cycles and
// publishes it on distance_raw, with rise/width timeouts and a post-shot holdoff.
//
// state     | meaning
// IDLE      | waiting for start or auto_en
// TRIG      | trig high for TRIG_CYCLES
// WAIT_RISE | waiting for echo rise, bounded by RISE_TIMEOUT
// MEASURE   | counting echo high cycles, bounded by ECHO_MAX
// HOLDOFF   | sensor quiet time before the next shot
module ultrasonic_echo_capture
  import fuel_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned RISE_TIMEOUT   = RISE_TIMEOUT_DEF,
  parameter int unsigned ECHO_MAX       = ECHO_MAX_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance_raw,
  output logic              raw_valid,
  output logic              timeout,
  output logic              busy
);

  localparam logic [DIST_W-1:0] TRIG_LAST = DIST_W'(TRIG_CYCLES - 1);
  localparam logic [DIST_W-1:0] RISE_LAST = DIST_W'(RISE_TIMEOUT - 1);
  localparam logic [DIST_W-1:0] ECHO_LIM  = DIST_W'(ECHO_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  echo_state_t       state, state_n;
  logic [DIST_W-1:0] cnt, cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [DIST_W-1:0] dist_n;
  logic              valid_n, tmo_n;
  logic              echo_s, echo_rise, echo_fall;

  echo_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .echo  (echo),
    .level (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold_cnt;
    dist_n  = distance_raw;
    valid_n = 1'b0;
    tmo_n   = timeout;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start || auto_en) state_n = S_TRIG;
      end
      S_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_n = S_WAIT_RISE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        // the edge detector ignores a level that was already high on entry
        if (echo_rise) begin
          state_n = S_MEASURE;
          cnt_n   = DIST_W'(1);
        end else if (cnt == RISE_LAST) begin
          state_n = S_HOLDOFF;
          tmo_n   = 1'b1;
          hold_n  = HOLD_LOAD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_n = S_HOLDOFF;
          dist_n  = cnt;
          valid_n = 1'b1;
          tmo_n   = 1'b0;
          hold_n  = HOLD_LOAD;
        end else if (cnt == ECHO_LIM) begin
          state_n = S_HOLDOFF;
          tmo_n   = 1'b1;
          hold_n  = HOLD_LOAD;
        end else if (echo_s) begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == '0) state_n = S_IDLE;
        else hold_n = hold_cnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      hold_cnt     <= '0;
      distance_raw <= '0;
      raw_valid    <= 1'b0;
      timeout      <= 1'b0;
      trig         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      hold_cnt     <= hold_n;
      distance_raw <= dist_n;
      raw_valid    <= valid_n;
      timeout      <= tmo_n;
      trig         <= (state_n == S_TRIG);
      busy         <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_capture.sv
// Directed bench for ultrasonic_echo_capture with shortened timing parameters
// so every timeout and holdoff path is reachable in a short run.
module tb_ultrasonic_echo_capture;

  localparam int TC = 8;
  localparam int RT = 200;
  localparam int EM = 300;
  localparam int HO = 50;

  logic        clk = 1'b0;
  logic        rst, start, auto_en, echo;
  logic        trig, raw_valid, timeout, busy;
  logic [20:0] distance_raw;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;

  ultrasonic_echo_capture #(
    .TRIG_CYCLES   (TC),
    .RISE_TIMEOUT  (RT),
    .ECHO_MAX      (EM),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .auto_en     (auto_en),
    .echo        (echo),
    .trig        (trig),
    .distance_raw(distance_raw),
    .raw_valid   (raw_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string name;
    int    width;
    int    delay;
    int    exp_valid;
    int    exp_dist;
    int    exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (raw_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return trig;
      1:       return busy;
      2:       return raw_valid;
      default: return timeout;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic lvl, input int bound, input string nm);
    int   n = 0;
    logic v = sel(which);
    while (v !== lvl && n < bound) begin
      step();
      n++;
      v = sel(which);
    end
    checks++;
    if (v !== lvl) begin
      errors++;
      $display("FAIL %s: wait expired after %0d cycles, signal %b, expected %b", nm, n, v, lvl);
    end
  endtask

  task automatic count_trig(input string nm);
    int hi = 0;
    while (trig === 1'b1 && hi < 100) begin
      hi++;
      step();
    end
    check({nm, "_trig_len"}, hi, TC);
  endtask

  task automatic run_meas(input vec_t v);
    int fall_cyc = 0;
    int seen = 0;
    valid_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({v.name, "_busy"}, int'(busy), 1);
    count_trig(v.name);
    repeat (v.delay) step();
    if (v.width > 0) begin
      echo = 1'b1;
      repeat (v.width) step();
      echo = 1'b0;
    end
    fall_cyc = cyc;
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_sig(1, 1'b0, RT + EM + HO + 100, {v.name, "_done"});
    check({v.name, "_valid_cnt"}, valid_cnt, v.exp_valid);
    if (v.exp_valid != 0) check({v.name, "_latency"}, valid_cyc - fall_cyc, 3);
    check({v.name, "_dist"}, int'(distance_raw), v.exp_dist);
    check({v.name, "_timeout"}, int'(timeout), v.exp_to);
    for (int i = 0; i < 5; i++) begin
      step();
      seen += int'(trig) + int'(busy);
    end
    check({v.name, "_no_requeue"}, seen, 0);
  endtask

  initial begin
    int n;
    int g;

    vecs[0] = '{"w123",     123,   3, 1, 123, 0};
    vecs[1] = '{"w1",         1,   0, 1,   1, 0};
    vecs[2] = '{"no_echo",    0,   0, 0,   1, 1};
    vecs[3] = '{"w_max",     EM,   4, 1,  EM, 0};
    vecs[4] = '{"w_over",  EM+1,   4, 0,  EM, 1};
    vecs[5] = '{"w2",         2,  17, 1,   2, 0};
    vecs[6] = '{"late_ok",   77, RT-3, 1,  77, 0};
    vecs[7] = '{"late_tmo",  20, RT-2, 0,  77, 1};

    rst = 1'b1; start = 1'b0; auto_en = 1'b0; echo = 1'b0;
    repeat (5) step();
    check("rst_trig",  int'(trig), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(raw_valid), 0);
    check("rst_dist",  int'(distance_raw), 0);
    check("rst_to",    int'(timeout), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_meas(vecs[i]);

    // reset in the middle of TRIG
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("midtrig_pre_trig", int'(trig), 1);
    rst = 1'b1;
    step();
    check("midrst_trig",  int'(trig), 0);
    check("midrst_busy",  int'(busy), 0);
    check("midrst_dist",  int'(distance_raw), 0);
    check("midrst_to",    int'(timeout), 0);
    check("midrst_valid", int'(raw_valid), 0);
    repeat (4) step();
    rst = 1'b0;
    step();
    step();
    check("midrst_idle", int'(busy), 0);

    // rise timeout lands exactly RT cycles after trig falls
    valid_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    count_trig("rise_tmo");
    n = 0;
    while (timeout !== 1'b1 && n < RT + 20) begin
      step();
      n++;
    end
    check("rise_tmo_cycles", n, RT);
    wait_sig(1, 1'b0, HO + 20, "rise_tmo_done");
    check("rise_tmo_valid", valid_cnt, 0);
    check("rise_tmo_dist", int'(distance_raw), 0);

    run_meas('{"clear_to", 40, 2, 1, 40, 0});

    // echo already high when trig ends is not a rise
    valid_cnt = 0;
    echo = 1'b1;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    count_trig("stuck_hi");
    n = 0;
    while (timeout !== 1'b1 && n < RT + EM + 20) begin
      step();
      n++;
    end
    check("stuck_hi_cycles", n, RT);
    wait_sig(1, 1'b0, HO + 20, "stuck_hi_done");
    echo = 1'b0;
    check("stuck_hi_valid", valid_cnt, 0);
    check("stuck_hi_dist", int'(distance_raw), 40);
    repeat (4) step();

    // free-running: two shots, results in order, holdoff before re-trigger
    valid_cnt = 0;
    auto_en = 1'b1;
    wait_sig(0, 1'b1, 5, "auto_trig1_rise");
    wait_sig(0, 1'b0, TC + 5, "auto_trig1_fall");
    repeat (5) step();
    echo = 1'b1;
    repeat (12) step();
    echo = 1'b0;
    wait_sig(2, 1'b1, 10, "auto_valid1");
    check("auto_dist1", int'(distance_raw), 12);
    g = 0;
    while (trig !== 1'b1 && g < HO + 20) begin
      step();
      g++;
    end
    checks++;
    if (g < HO || g > HO + 1) begin
      errors++;
      $display("FAIL auto_gap: got %0d cycles, expected %0d..%0d", g, HO, HO + 1);
    end
    wait_sig(0, 1'b0, TC + 5, "auto_trig2_fall");
    auto_en = 1'b0;
    repeat (5) step();
    echo = 1'b1;
    repeat (250) step();
    echo = 1'b0;
    wait_sig(2, 1'b1, 10, "auto_valid2");
    check("auto_dist2", int'(distance_raw), 250);
    wait_sig(1, 1'b0, HO + 20, "auto_done");
    check("auto_valid_cnt", valid_cnt, 2);
    check("auto_to", int'(timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
